// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT butterfly address generator.
package fft_pkg;

  // Default largest transform: 2^10 points, twiddle ROM of 512 entries.
  localparam int FFT_MAX_LOG2N = 10;

  typedef logic [FFT_MAX_LOG2N-1:0] fft_idx_t;
  typedef logic [FFT_MAX_LOG2N-2:0] fft_tw_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fft_addr_state_e;

  // Schedule selector encodings for dif_i.
  localparam logic DIT = 1'b0;
  localparam logic DIF = 1'b1;

endpackage

// File: rtl/fft_addr_gen_if.sv
// Butterfly descriptor channel: valid/ready handshake plus operand/twiddle indices.
interface fft_addr_gen_if #(
  parameter int MAX_LOG2N = 10
);
  logic                 valid_o;
  logic                 ready_i;
  logic [MAX_LOG2N-1:0] idx_a_o;
  logic [MAX_LOG2N-1:0] idx_b_o;
  logic [MAX_LOG2N-2:0] tw_idx_o;
  logic [3:0]           stage_o;
  logic                 stage_last_o;

  modport master (
    output valid_o, idx_a_o, idx_b_o, tw_idx_o, stage_o, stage_last_o,
    input  ready_i
  );

  modport slave (
    input  valid_o, idx_a_o, idx_b_o, tw_idx_o, stage_o, stage_last_o,
    output ready_i
  );
endinterface

// File: rtl/fft_bfly_index.sv
// Pure combinational map from (stage, butterfly count, size, ordering) to
// operand indices, twiddle index and end-of-stage flag.
module fft_bfly_index
  import fft_pkg::*;
#(
  parameter int MAX_LOG2N = FFT_MAX_LOG2N
) (
  input  logic [3:0]           stage_i,
  input  logic [MAX_LOG2N-1:0] k_i,
  input  logic [3:0]           l_i,
  input  logic                 dif_i,
  output logic [MAX_LOG2N-1:0] idx_a_o,
  output logic [MAX_LOG2N-1:0] idx_b_o,
  output logic [MAX_LOG2N-2:0] tw_idx_o,
  output logic                 last_o
);

  localparam logic [MAX_LOG2N-1:0] ONE    = {{(MAX_LOG2N-1){1'b0}}, 1'b1};
  localparam logic [3:0]           TW_TOP = 4'(MAX_LOG2N - 1);

  logic [3:0]           h;
  logic [MAX_LOG2N-1:0] half;
  logic [MAX_LOG2N-1:0] j;
  logic [MAX_LOG2N-1:0] g;
  logic [MAX_LOG2N-1:0] a;
  logic [MAX_LOG2N-1:0] n_half;

  // Split k into group and in-group offset around the current half span.
  always_comb begin
    h        = (dif_i == DIF) ? (l_i - 4'd1 - stage_i) : stage_i;
    half     = ONE << h;
    j        = k_i & (half - ONE);
    g        = k_i >> h;
    a        = (g << (h + 4'd1)) | j;
    n_half   = ONE << (l_i - 4'd1);
    idx_a_o  = a;
    idx_b_o  = a + half;
    // j < half <= N_max/2, so the scaled twiddle always fits the ROM index.
    tw_idx_o = j[MAX_LOG2N-2:0] << (TW_TOP - h);
    last_o   = (k_i == (n_half - ONE));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// Stage/butterfly sequencer for an in-place radix-2 FFT; emits one
// registered descriptor per accepted handshake.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int MAX_LOG2N = FFT_MAX_LOG2N
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic           dif_i,
  input  logic [3:0]     log2n_i,
  input  logic           abort_i,
  output logic           busy_o,
  output logic           done_o,
  fft_addr_gen_if.master desc
);

  localparam logic [3:0]           L_MAX = 4'(MAX_LOG2N);
  localparam logic [MAX_LOG2N-1:0] K_ONE = {{(MAX_LOG2N-1){1'b0}}, 1'b1};

  fft_addr_state_e      state_q, state_d;
  logic [3:0]           s_q, s_d;
  logic [3:0]           l_q, l_d;
  logic [MAX_LOG2N-1:0] k_q, k_d;
  logic                 dif_q, dif_d;

  logic                 valid_q, valid_d;
  logic [MAX_LOG2N-1:0] idx_a_q, idx_a_d;
  logic [MAX_LOG2N-1:0] idx_b_q, idx_b_d;
  logic [MAX_LOG2N-2:0] tw_q, tw_d;
  logic [3:0]           stage_q, stage_d;
  logic                 last_q, last_d;

  logic [MAX_LOG2N-1:0] nx_a, nx_b;
  logic [MAX_LOG2N-2:0] nx_tw;
  logic                 nx_last;
  logic                 accept;
  logic                 final_acc;

  assign accept    = valid_q & desc.ready_i;
  assign final_acc = accept & last_q & (s_q == (l_q - 4'd1));

  // Descriptor for the next counter values; registered below so outputs
  // change only on acceptance and hold during stalls.
  fft_bfly_index #(.MAX_LOG2N(MAX_LOG2N)) u_index (
    .stage_i  (s_d),
    .k_i      (k_d),
    .l_i      (l_d),
    .dif_i    (dif_d),
    .idx_a_o  (nx_a),
    .idx_b_o  (nx_b),
    .tw_idx_o (nx_tw),
    .last_o   (nx_last)
  );

  // State and output registers; reset discards any transform in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      s_q     <= '0;
      l_q     <= '0;
      k_q     <= '0;
      dif_q   <= 1'b0;
      valid_q <= 1'b0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      tw_q    <= '0;
      stage_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      l_q     <= l_d;
      k_q     <= k_d;
      dif_q   <= dif_d;
      valid_q <= valid_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      tw_q    <= tw_d;
      stage_q <= stage_d;
      last_q  <= last_d;
    end
  end

  // Next state and counters; abort beats both start and acceptance.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    l_d     = l_q;
    dif_d   = dif_q;
    case (state_q)
      IDLE: begin
        if (!abort_i && start_i) begin
          l_d     = (log2n_i > L_MAX) ? L_MAX : log2n_i;
          dif_d   = dif_i;
          s_d     = 4'd0;
          k_d     = '0;
          state_d = (l_d == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (final_acc) begin
          state_d = DONE;
        end else if (accept) begin
          if (last_q) begin
            s_d = s_q + 4'd1;
            k_d = '0;
          end else begin
            k_d = k_q + K_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: descriptor fields are zero whenever nothing is offered.
  always_comb begin
    valid_d = (state_d == RUN);
    idx_a_d = '0;
    idx_b_d = '0;
    tw_d    = '0;
    stage_d = '0;
    last_d  = 1'b0;
    if (valid_d) begin
      idx_a_d = nx_a;
      idx_b_d = nx_b;
      tw_d    = nx_tw;
      stage_d = s_d;
      last_d  = nx_last;
    end
    busy_o = (state_q != IDLE);
    done_o = (state_q == DONE);
  end

  assign desc.valid_o      = valid_q;
  assign desc.idx_a_o      = idx_a_q;
  assign desc.idx_b_o      = idx_b_q;
  assign desc.tw_idx_o     = tw_q;
  assign desc.stage_o      = stage_q;
  assign desc.stage_last_o = last_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Self-checking bench for fft_addr_gen with a small transform table.
module tb_fft_addr_gen;

  localparam int MAXL = 4;
  localparam int NMAX_HALF = 8;

  typedef struct {
    int a;
    int b;
    int tw;
    int stage;
    bit last;
  } desc_t;

  typedef struct {
    bit dif;
    int log2n;
    int pos;
    desc_t d;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       dif = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] log2n = 4'd0;
  logic       busy;
  logic       done;

  fft_addr_gen_if #(.MAX_LOG2N(MAXL)) bus ();

  fft_addr_gen #(.MAX_LOG2N(MAXL)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .dif_i   (dif),
    .log2n_i (log2n),
    .abort_i (abort),
    .busy_o  (busy),
    .done_o  (done),
    .desc    (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passes = 0;
  desc_t exp_q[$];
  desc_t got_q[$];
  vec_t  tbl[$];

  task automatic chk(input bit ok, input string name, input string act, input string exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %s expected %s", name, act, exp);
  endtask

  function automatic string fmt(desc_t d);
    return $sformatf("(%0d,%0d,%0d,s%0d,l%0d)", d.a, d.b, d.tw, d.stage, d.last);
  endfunction

  function automatic bit same(desc_t x, desc_t y);
    return x.a == y.a && x.b == y.b && x.tw == y.tw && x.stage == y.stage && x.last == y.last;
  endfunction

  function automatic desc_t cur_desc();
    desc_t d;
    d.a = int'(bus.idx_a_o);
    d.b = int'(bus.idx_b_o);
    d.tw = int'(bus.tw_idx_o);
    d.stage = int'(bus.stage_o);
    d.last = bus.stage_last_o;
    return d;
  endfunction

  function automatic void add(bit d, int l, int p, int a, int b, int tw, int st, bit last);
    vec_t v;
    v.dif = d; v.log2n = l; v.pos = p;
    v.d.a = a; v.d.b = b; v.d.tw = tw; v.d.stage = st; v.d.last = last;
    tbl.push_back(v);
  endfunction

  // Reference schedule: each stage pairs every index i whose half-span bit is
  // clear with i+half, in ascending order; twiddle scales i mod half to N_max.
  function automatic void build_model(bit d, int l2);
    int L;
    int n;
    L = (l2 > MAXL) ? MAXL : l2;
    n = 1 << L;
    exp_q.delete();
    for (int s = 0; s < L; s++) begin
      int h;
      int half;
      int cnt;
      h = d ? (L - 1 - s) : s;
      half = 2 ** h;
      cnt = 0;
      for (int i = 0; i < n; i++) begin
        if ((i / half) % 2 == 0) begin
          desc_t e;
          cnt++;
          e.a = i; e.b = i + half; e.tw = (i % half) * (NMAX_HALF / half);
          e.stage = s; e.last = (cnt == n / 2);
          exp_q.push_back(e);
        end
      end
    end
  endfunction

  // One transform: start, collect accepted descriptors with random ready,
  // check stall stability, latency, cycle count and the done pulse.
  task automatic do_run(input bit d, input int l2, input int pct, input bit poke, input string tag);
    int    cyc;
    int    stalls;
    int    leff;
    bit    seen_done;
    bit    hold;
    desc_t held;
    desc_t cur;
    leff = (l2 > MAXL) ? MAXL : l2;
    got_q.delete();
    cyc = 0; stalls = 0; seen_done = 0; hold = 0;
    @(negedge clk);
    start = 1'b1; dif = d; log2n = l2[3:0];
    @(negedge clk);
    start = 1'b0; dif = 1'($urandom); log2n = 4'($urandom);
    while (!seen_done && cyc < 2000) begin
      cyc++;
      cur = cur_desc();
      if (cyc == 1) begin
        chk(bus.valid_o == (leff > 0), {tag, "_first_valid"}, $sformatf("%0d", bus.valid_o), $sformatf("%0d", leff > 0));
        if (leff > 0) chk(busy == 1'b1, {tag, "_busy"}, $sformatf("%0d", busy), "1");
      end
      if (poke) begin
        if (cyc == 3) begin start = 1'b1; log2n = 4'd1; dif = ~d; end
        else if (cyc == 4) start = 1'b0;
      end
      if (hold) begin
        chk(bus.valid_o && same(cur, held), {tag, "_stall_stable"}, fmt(cur), fmt(held));
        hold = 0;
      end
      if (done) begin
        seen_done = 1;
      end else begin
        bus.ready_i = ($urandom_range(99) < pct);
        if (bus.valid_o) begin
          if (bus.ready_i) begin
            got_q.push_back(cur);
            $display("%s desc #%0d a=%0d b=%0d tw=%0d stage=%0d last=%0d", tag, got_q.size(), cur.a, cur.b, cur.tw, cur.stage, cur.last);
          end else begin
            stalls++;
            hold = 1;
            held = cur;
          end
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk(seen_done, {tag, "_done_seen"}, $sformatf("%0d", seen_done), "1");
    chk(cyc == got_q.size() + stalls + 1, {tag, "_cycles"}, $sformatf("%0d", cyc), $sformatf("%0d", got_q.size() + stalls + 1));
    @(negedge clk);
    chk(!done && !busy && !bus.valid_o, {tag, "_done_pulse"}, $sformatf("done=%0d busy=%0d valid=%0d", done, busy, bus.valid_o), "all 0");
  endtask

  task automatic check_model(input string tag);
    int n;
    chk(got_q.size() == exp_q.size(), {tag, "_count"}, $sformatf("%0d", got_q.size()), $sformatf("%0d", exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk(same(got_q[i], exp_q[i]), $sformatf("%s_desc%0d", tag, i), fmt(got_q[i]), fmt(exp_q[i]));
  endtask

  task automatic check_table(input bit d, input int l2, input string tag);
    do_run(d, l2, 100, 0, tag);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].dif == d && tbl[i].log2n == l2) begin
        if (tbl[i].pos < got_q.size())
          chk(same(got_q[tbl[i].pos], tbl[i].d), $sformatf("%s_vec%0d", tag, tbl[i].pos), fmt(got_q[tbl[i].pos]), fmt(tbl[i].d));
        else
          chk(1'b0, $sformatf("%s_vec%0d", tag, tbl[i].pos), "missing", fmt(tbl[i].d));
      end
    end
  endtask

  initial begin
    // DIT, N=8
    add(0,3, 0, 0,1,0,0,0); add(0,3, 1, 2,3,0,0,0); add(0,3, 2, 4,5,0,0,0); add(0,3, 3, 6,7,0,0,1);
    add(0,3, 4, 0,2,0,1,0); add(0,3, 5, 1,3,4,1,0); add(0,3, 6, 4,6,0,1,0); add(0,3, 7, 5,7,4,1,1);
    add(0,3, 8, 0,4,0,2,0); add(0,3, 9, 1,5,2,2,0); add(0,3,10, 2,6,4,2,0); add(0,3,11, 3,7,6,2,1);
    // DIF, N=8
    add(1,3, 0, 0,4,0,0,0); add(1,3, 1, 1,5,2,0,0); add(1,3, 2, 2,6,4,0,0); add(1,3, 3, 3,7,6,0,1);
    add(1,3, 4, 0,2,0,1,0); add(1,3, 5, 1,3,4,1,0); add(1,3, 6, 4,6,0,1,0); add(1,3, 7, 5,7,4,1,1);
    add(1,3, 8, 0,1,0,2,0); add(1,3, 9, 2,3,0,2,0); add(1,3,10, 4,5,0,2,0); add(1,3,11, 6,7,0,2,1);
    // N=2: single butterfly
    add(0,1, 0, 0,1,0,0,1);

    bus.ready_i = 1'b0;
    repeat (3) @(negedge clk);
    chk(!bus.valid_o && !busy && !done && bus.idx_a_o == 0 && bus.idx_b_o == 0 && bus.tw_idx_o == 0
        && bus.stage_o == 0 && !bus.stage_last_o, "reset_state", fmt(cur_desc()), "all 0");
    rst_n = 1'b1;

    check_table(0, 3, "dit3");
    check_table(1, 3, "dif3");
    check_table(0, 1, "n2");
    chk(got_q.size() == 1, "n2_count", $sformatf("%0d", got_q.size()), "1");

    // Backpressure on the 16-point DIT schedule, with a start poke mid-run.
    build_model(0, 4);
    do_run(0, 4, 50, 1, "bp16");
    check_model("bp16");

    // Size clamp and empty transform.
    build_model(1, 7);
    do_run(1, 7, 100, 0, "clamp");
    check_model("clamp");
    build_model(0, 0);
    do_run(0, 0, 100, 0, "n1");
    check_model("n1");

    // Abort on the 5th descriptor.
    @(negedge clk);
    start = 1'b1; dif = 1'b0; log2n = 4'd4; bus.ready_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk(bus.valid_o && bus.idx_a_o == 8, "abort_fifth", $sformatf("v=%0d a=%0d", bus.valid_o, bus.idx_a_o), "v=1 a=8");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk(!bus.valid_o && !busy, "abort_drop", $sformatf("v=%0d busy=%0d", bus.valid_o, busy), "v=0 busy=0");
    for (int i = 0; i < 4; i++) begin
      chk(!done && !bus.valid_o, "abort_no_done", $sformatf("done=%0d v=%0d", done, bus.valid_o), "0");
      @(negedge clk);
    end
    build_model(0, 4);
    do_run(0, 4, 100, 0, "restart");
    check_model("restart");

    // Asynchronous reset in the middle of a stage.
    @(negedge clk);
    start = 1'b1; dif = 1'b1; log2n = 4'd4; bus.ready_i = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(!bus.valid_o && !busy && !done && bus.idx_a_o == 0 && bus.idx_b_o == 0 && bus.tw_idx_o == 0
        && bus.stage_o == 0 && !bus.stage_last_o, "async_reset", fmt(cur_desc()), "all 0");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized schedules against the reference model.
    for (int r = 0; r < 10; r++) begin
      bit rd;
      int rl;
      rd = 1'($urandom);
      rl = $urandom_range(7);
      build_model(rd, rl);
      do_run(rd, rl, 50, 0, $sformatf("rnd%0d", r));
      check_model($sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
